// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: drives the fetch PC, captures memory data one cycle later and
// queues it for issue over valid/ready. Optional head bypass via `IFQ_BYPASS_EN.
// Ports: clk1, rst_n (async, active-low), pc, mem_instr, iq_valid/iq_instr/iq_pc,
// iq_ready, redirect/redirect_pc, count, fetch_done.
module instr_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int PROG_LEN = 6,
  parameter int AW       = 32
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  output logic [AW-1:0]              pc,
  input  logic [31:0]                mem_instr,
  output logic                       iq_valid,
  output logic [31:0]                iq_instr,
  output logic [AW-1:0]              iq_pc,
  input  logic                       iq_ready,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       fetch_done
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    RUN,
    STOP
  } state_t;

  state_t        state;
  logic          req_q;
  logic [AW-1:0] req_pc_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];

  logic [CW:0]   pending;
  logic          issue;
  logic          push;
  logic          stored;
  logic          byp;
  logic          pop;
  logic          wr;
  logic          rd;

  // Slot reservation counts the in-flight read so a return always fits.
  assign pending = {1'b0, count} + (CW+1)'(req_q);
  assign issue   = (state == RUN) && !redirect
                && (pending < (CW+1)'(DEPTH));
  assign push    = req_q && !redirect;
  assign stored  = (count != '0);

`ifdef IFQ_BYPASS_EN
  assign byp = !stored && push;
`else
  assign byp = 1'b0;
`endif

  assign iq_valid = (stored || byp) && !redirect;
  assign pop      = iq_valid && iq_ready;
  // A bypassed word taken the same cycle never lands in storage.
  assign wr       = push && !(byp && iq_ready);
  assign rd       = pop && stored;

  always_comb begin
    iq_instr = '0;
    iq_pc    = '0;
    if (byp) begin
      iq_instr = mem_instr;
      iq_pc    = req_pc_q;
    end else if (stored) begin
      iq_instr = q_instr[rd_ptr];
      iq_pc    = q_pc[rd_ptr];
    end
  end

  assign fetch_done = (state == STOP) && !stored && !req_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= '0;
      req_q    <= 1'b0;
      req_pc_q <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      req_q    <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      if (redirect_pc >= AW'(PROG_LEN)) begin
        state <= STOP;
      end else begin
        state <= RUN;
      end
    end else begin
      if (issue) begin
        pc       <= pc + AW'(1);
        req_q    <= 1'b1;
        req_pc_q <= pc;
        if (pc + AW'(1) == AW'(PROG_LEN)) begin
          state <= STOP;
        end
      end else begin
        req_q <= 1'b0;
      end
      if (wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (wr) begin
      q_instr[wr_ptr] <= mem_instr;
      q_pc[wr_ptr]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for instr_fetch_queue with a
// registered instruction memory model.
module tb_instr_fetch_queue;

  logic        clk1;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] mem_instr;
  logic        iq_valid;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        iq_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic        fetch_done;

  logic [31:0] rom [0:7];
  logic [31:0] log_pc [$];
  logic [31:0] log_instr [$];
  int          errors;
  int          checks;
  int          maxc;
  int          first_valid;
  int          ncyc;

  instr_fetch_queue dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .pc          (pc),
    .mem_instr   (mem_instr),
    .iq_valid    (iq_valid),
    .iq_instr    (iq_instr),
    .iq_pc       (iq_pc),
    .iq_ready    (iq_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count),
    .fetch_done  (fetch_done)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always @(posedge clk1) mem_instr <= rom[pc[2:0]];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    iq_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    log_pc.delete();
    log_instr.delete();
    maxc        = 0;
    ncyc        = 0;
    first_valid = 0;
  endtask

  // Set inputs for the next edge, then log what that edge will pop.
  task automatic cyc(input logic rdy,
                     input logic rdr,
                     input logic [31:0] rpc);
    @(negedge clk1);
    iq_ready    = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
    ncyc++;
    if (int'(count) > maxc) maxc = int'(count);
    if (iq_valid && first_valid == 0) first_valid = ncyc;
    if (iq_valid && iq_ready && !redirect) begin
      log_pc.push_back(iq_pc);
      log_instr.push_back(iq_instr);
    end
  endtask

  task automatic run(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(rdy, 1'b0, '0);
  endtask

  task automatic chk_seq(input string tag,
                         input int first,
                         input int n);
    chk({tag, "_n"}, 64'(log_pc.size()), 64'(n));
    for (int i = 0; i < n && i < log_pc.size(); i++) begin
      chk($sformatf("%s_pc%0d", tag, i),
          64'(log_pc[i]), 64'(first + i));
      chk($sformatf("%s_in%0d", tag, i),
          64'(log_instr[i]), 64'(rom[first + i]));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rom[0] = 32'hA5A5_2123;
    rom[1] = 32'h0000_3456;
    rom[2] = 32'h1111_1A2B;
    rom[3] = 32'h0000_4C5D;
    rom[4] = 32'hFFFF_7E0F;
    rom[5] = 32'h0000_0981;
    rom[6] = 32'hDEAD_BEEF;
    rom[7] = 32'hCAFE_F00D;
    rst_n       = 1'b0;
    iq_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset state
    #3;
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(iq_valid), 64'd0);
    chk("rst_done", 64'(fetch_done), 64'd0);
    chk("rst_instr", 64'(iq_instr), 64'd0);
    chk("rst_iqpc", 64'(iq_pc), 64'd0);

    // 1 + 6: streaming, latency from reset release
    do_reset();
    run(1'b1, 14);
`ifdef IFQ_BYPASS_EN
    chk("t6_lat", 64'(first_valid), 64'd1);
`else
    chk("t6_lat", 64'(first_valid), 64'd2);
`endif
    chk_seq("t1", 0, 6);
    chk("t1_done", 64'(fetch_done), 64'd1);
    chk("t1_pc", 64'(pc), 64'd6);
    chk("t1_count", 64'(count), 64'd0);

    // 2: back-pressure saturates at DEPTH
    do_reset();
    run(1'b0, 10);
    chk("t2_count", 64'(count), 64'd4);
    chk("t2_pc", 64'(pc), 64'd4);
    chk("t2_nopop", 64'(log_pc.size()), 64'd0);
    chk("t2_done", 64'(fetch_done), 64'd0);
    run(1'b1, 14);
    chk_seq("t2", 0, 6);
    chk("t2_max", 64'(maxc), 64'd4);
    chk("t2_fdone", 64'(fetch_done), 64'd1);

    // 3: redirect with 3 queued + read in flight
    do_reset();
    run(1'b0, 4);
    chk("t3_pre", 64'(count), 64'd3);
    cyc(1'b1, 1'b1, 32'd2);
    chk("t3_vgate", 64'(iq_valid), 64'd0);
    cyc(1'b1, 1'b0, '0);
    chk("t3_count", 64'(count), 64'd0);
    chk("t3_valid", 64'(iq_valid), 64'd0);
    chk("t3_pc", 64'(pc), 64'd2);
    run(1'b1, 12);
    chk_seq("t3", 2, 4);
    chk("t3_done", 64'(fetch_done), 64'd1);

    // 4: toggle ready with a full queue
    do_reset();
    run(1'b0, 6);
    chk("t4_full", 64'(count), 64'd4);
    for (int i = 0; i < 24; i++) cyc(~i[0], 1'b0, '0);
    run(1'b1, 6);
    chk_seq("t4", 0, 6);
    chk("t4_max", 64'(maxc), 64'd4);

    // 5: mid-stream async reset
    do_reset();
    run(1'b0, 4);
    chk("t5_pre", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(iq_valid), 64'd0);
    chk("t5_pc", 64'(pc), 64'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    log_pc.delete();
    log_instr.delete();
    run(1'b1, 14);
    chk_seq("t5", 0, 6);

    // Redirect past the end of programme lands straight in STOP
    cyc(1'b1, 1'b1, 32'd7);
    cyc(1'b1, 1'b0, '0);
    chk("rd_stop_done", 64'(fetch_done), 64'd1);
    chk("rd_stop_pc", 64'(pc), 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
